// File: rtl/rmt_pkg.sv
// Shared PHV layout constants for the match-action stage.
//   PHV_LEN      : total PHV width (6B + 4B + 2B groups + remain bits)
//   WIDTH_6B/4B/2B: container widths in bits
//   NUM_CONT     : containers per ALU group
//   REMAIN_W     : metadata/conditional bits that bypass the ALUs
//   next_count   : occupancy a merge FIFO will hold after the coming edge
package rmt_pkg;

    localparam int WIDTH_6B   = 48;
    localparam int WIDTH_4B   = 32;
    localparam int WIDTH_2B   = 16;
    localparam int NUM_CONT   = 8;
    localparam int REMAIN_W   = 356;
    localparam int PHV_LEN    = NUM_CONT * (WIDTH_6B + WIDTH_4B + WIDTH_2B) + REMAIN_W;
    localparam int FIFO_DEPTH = 4;

    // A push into a full FIFO only lands when a pop frees a slot in the same
    // cycle; otherwise it is dropped and the count does not move.
    function automatic int next_count(input int cnt, input logic push,
                                      input logic full, input logic pop);
        int n;
        n = cnt;
        if (push && (!full || pop)) n = n + 1;
        if (pop && (cnt != 0))      n = n - 1;
        return n;
    endfunction

endpackage

// File: rtl/merge_fifo.sv
// In-order alignment FIFO used once per PHV group.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write request and data; ignored when full unless popping
//   pop, dout  : read request; dout shows the head entry combinationally
//   full, empty, count : occupancy status (count ranges 0..DEPTH)
module merge_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // When full, a simultaneous pop frees the head slot, which is exactly
    // where wr_ptr points; the read sees the old value before the write lands.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/phv_merger.sv
// Re-aligns the three ALU result groups and the bypassed remain bits, which
// may arrive on different cycles, and reassembles one PHV per set.
//   clk, rst_n          : clock, asynchronous active-low reset
//   alu_out_6B/4B/2B    : ALU group results (+ _valid), container 7 in MSBs
//   phv_remain_data     : metadata bits (+ phv_remain_valid)
//   phv_out             : {6B, 4B, 2B, remain}; phv_out_valid / phv_out_ready
//   stage_ready         : every FIFO has at least two free slots
//   overflow            : sticky drop flags {6B, 4B, 2B, remain}
//
// Output handshake: phv_out is offered while phv_out_valid is high and is
// consumed on an edge where phv_out_ready is also high; while valid is high
// and ready low, phv_out is frozen and no FIFO is popped.
module phv_merger
    import rmt_pkg::*;
#(
    parameter int PHV_LEN    = rmt_pkg::PHV_LEN,
    parameter int width_6B   = rmt_pkg::WIDTH_6B,
    parameter int width_4B   = rmt_pkg::WIDTH_4B,
    parameter int width_2B   = rmt_pkg::WIDTH_2B,
    parameter int FIFO_DEPTH = rmt_pkg::FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CONT*width_6B-1:0] alu_out_6B,
    input  logic                         alu_out_6B_valid,
    input  logic [NUM_CONT*width_4B-1:0] alu_out_4B,
    input  logic                         alu_out_4B_valid,
    input  logic [NUM_CONT*width_2B-1:0] alu_out_2B,
    input  logic                         alu_out_2B_valid,
    input  logic [REMAIN_W-1:0]          phv_remain_data,
    input  logic                         phv_remain_valid,
    output logic [PHV_LEN-1:0]           phv_out,
    output logic                         phv_out_valid,
    input  logic                         phv_out_ready,
    output logic                         stage_ready,
    output logic [3:0]                   overflow
);

    localparam int W6 = NUM_CONT * width_6B;
    localparam int W4 = NUM_CONT * width_4B;
    localparam int W2 = NUM_CONT * width_2B;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [W6-1:0]       dout_6b;
    logic [W4-1:0]       dout_4b;
    logic [W2-1:0]       dout_2b;
    logic [REMAIN_W-1:0] dout_rm;
    logic [3:0]          full_v, empty_v;
    logic [CW-1:0]       cnt_6b, cnt_4b, cnt_2b, cnt_rm;

    logic                fire;
    logic [PHV_LEN-1:0]  phv_out_q, phv_out_d;
    logic                phv_out_valid_q, phv_out_valid_d;
    logic [3:0]          overflow_q, overflow_d;
    logic                stage_ready_q, stage_ready_d;
    logic [3:0]          push_v;

    assign push_v = {alu_out_6B_valid, alu_out_4B_valid, alu_out_2B_valid, phv_remain_valid};

    merge_fifo #(.WIDTH(W6), .DEPTH(FIFO_DEPTH)) u_fifo_6b (
        .clk(clk), .rst_n(rst_n), .push(alu_out_6B_valid), .din(alu_out_6B),
        .pop(fire), .dout(dout_6b), .full(full_v[3]), .empty(empty_v[3]), .count(cnt_6b)
    );
    merge_fifo #(.WIDTH(W4), .DEPTH(FIFO_DEPTH)) u_fifo_4b (
        .clk(clk), .rst_n(rst_n), .push(alu_out_4B_valid), .din(alu_out_4B),
        .pop(fire), .dout(dout_4b), .full(full_v[2]), .empty(empty_v[2]), .count(cnt_4b)
    );
    merge_fifo #(.WIDTH(W2), .DEPTH(FIFO_DEPTH)) u_fifo_2b (
        .clk(clk), .rst_n(rst_n), .push(alu_out_2B_valid), .din(alu_out_2B),
        .pop(fire), .dout(dout_2b), .full(full_v[1]), .empty(empty_v[1]), .count(cnt_2b)
    );
    merge_fifo #(.WIDTH(REMAIN_W), .DEPTH(FIFO_DEPTH)) u_fifo_rm (
        .clk(clk), .rst_n(rst_n), .push(phv_remain_valid), .din(phv_remain_data),
        .pop(fire), .dout(dout_rm), .full(full_v[0]), .empty(empty_v[0]), .count(cnt_rm)
    );

    // A PHV is complete once every group has its Nth entry at the head.
    assign fire = (empty_v == 4'b0000) && (!phv_out_valid_q || phv_out_ready);

    always_comb begin
        phv_out_d       = phv_out_q;
        phv_out_valid_d = phv_out_valid_q;
        if (fire) begin
            phv_out_d       = {dout_6b, dout_4b, dout_2b, dout_rm};
            phv_out_valid_d = 1'b1;
        end else if (phv_out_ready) begin
            phv_out_valid_d = 1'b0;
        end

        // Only a push that finds its FIFO full with no pop is lost.
        overflow_d = overflow_q | (push_v & full_v & {4{!fire}});

        // Registered from the post-edge occupancy so stage_ready always
        // describes the counts the FIFOs hold right now.
        stage_ready_d =
            (next_count(int'(cnt_6b), push_v[3], full_v[3], fire) <= FIFO_DEPTH - 2) &&
            (next_count(int'(cnt_4b), push_v[2], full_v[2], fire) <= FIFO_DEPTH - 2) &&
            (next_count(int'(cnt_2b), push_v[1], full_v[1], fire) <= FIFO_DEPTH - 2) &&
            (next_count(int'(cnt_rm), push_v[0], full_v[0], fire) <= FIFO_DEPTH - 2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phv_out_q       <= '0;
            phv_out_valid_q <= 1'b0;
            overflow_q      <= 4'b0000;
            stage_ready_q   <= 1'b1;
        end else begin
            phv_out_q       <= phv_out_d;
            phv_out_valid_q <= phv_out_valid_d;
            overflow_q      <= overflow_d;
            stage_ready_q   <= stage_ready_d;
        end
    end

    assign phv_out       = phv_out_q;
    assign phv_out_valid = phv_out_valid_q;
    assign overflow      = overflow_q;
    assign stage_ready   = stage_ready_q;

endmodule

// File: tb/tb_phv_merger.sv
module tb_phv_merger;

    localparam int PHV_LEN = 1124;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [383:0]       alu_out_6B;
    logic               alu_out_6B_valid;
    logic [255:0]       alu_out_4B;
    logic               alu_out_4B_valid;
    logic [127:0]       alu_out_2B;
    logic               alu_out_2B_valid;
    logic [355:0]       phv_remain_data;
    logic               phv_remain_valid;
    logic [PHV_LEN-1:0] phv_out;
    logic               phv_out_valid;
    logic               phv_out_ready;
    logic               stage_ready;
    logic [3:0]         overflow;

    int n_vec  = 0;
    int n_miss = 0;

    phv_merger dut (
        .clk(clk), .rst_n(rst_n),
        .alu_out_6B(alu_out_6B), .alu_out_6B_valid(alu_out_6B_valid),
        .alu_out_4B(alu_out_4B), .alu_out_4B_valid(alu_out_4B_valid),
        .alu_out_2B(alu_out_2B), .alu_out_2B_valid(alu_out_2B_valid),
        .phv_remain_data(phv_remain_data), .phv_remain_valid(phv_remain_valid),
        .phv_out(phv_out), .phv_out_valid(phv_out_valid), .phv_out_ready(phv_out_ready),
        .stage_ready(stage_ready), .overflow(overflow)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- drivers ----------------
    task automatic idle();
        alu_out_6B_valid = 1'b0;
        alu_out_4B_valid = 1'b0;
        alu_out_2B_valid = 1'b0;
        phv_remain_valid = 1'b0;
        alu_out_6B = '0;
        alu_out_4B = '0;
        alu_out_2B = '0;
        phv_remain_data = '0;
    endtask

    task automatic drive(input logic v6, input logic [383:0] d6,
                         input logic v4, input logic [255:0] d4,
                         input logic v2, input logic [127:0] d2,
                         input logic vr, input logic [355:0] dr);
        alu_out_6B_valid = v6; alu_out_6B = d6;
        alu_out_4B_valid = v4; alu_out_4B = d4;
        alu_out_2B_valid = v2; alu_out_2B = d2;
        phv_remain_valid = vr; phv_remain_data = dr;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    // Distinct per-PHV group patterns derived from a tag.
    function automatic logic [383:0] pat6(input int k);
        logic [7:0] b; b = 8'(k + 8'h30); return {48{b}};
    endfunction
    function automatic logic [255:0] pat4(input int k);
        logic [7:0] b; b = 8'(k + 8'h60); return {32{b}};
    endfunction
    function automatic logic [127:0] pat2(input int k);
        logic [7:0] b; b = 8'(k + 8'h90); return {16{b}};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        phv_out_ready = 1'b1;
        tick();
        tick();
        n_vec++;
        if (phv_out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_valid: got %b exp 0", phv_out_valid); end
        n_vec++;
        if (phv_out !== '0) begin n_miss++; $display("FAIL reset_phv_out: got[63:0]=%h exp 0", phv_out[63:0]); end
        n_vec++;
        if (overflow !== 4'b0000) begin n_miss++; $display("FAIL reset_overflow: got %b exp 0000", overflow); end
        n_vec++;
        if (stage_ready !== 1'b1) begin n_miss++; $display("FAIL reset_stage_ready: got %b exp 1", stage_ready); end
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (phv_out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_release_valid: got %b exp 0", phv_out_valid); end
    endtask

    task automatic test_aligned();
        logic [PHV_LEN-1:0] exp;
        exp = {{48{8'hAA}}, {32{8'h55}}, {16{8'h0F}}, 356'h1};
        phv_out_ready = 1'b1;
        drive(1'b1, {48{8'hAA}}, 1'b1, {32{8'h55}}, 1'b1, {16{8'h0F}}, 1'b1, 356'h1);
        tick();
        idle();
        n_vec++;
        if (phv_out_valid !== 1'b0) begin n_miss++; $display("FAIL aligned_early: got %b exp 0", phv_out_valid); end
        tick();
        n_vec++;
        if (phv_out_valid !== 1'b1) begin n_miss++; $display("FAIL aligned_valid: got %b exp 1", phv_out_valid); end
        n_vec++;
        if (phv_out !== exp) begin
            n_miss++;
            $display("FAIL aligned_data: got[63:0]=%h exp[63:0]=%h diff_bits=%0d", phv_out[63:0], exp[63:0], $countones(phv_out ^ exp));
        end
        tick();
        n_vec++;
        if (phv_out_valid !== 1'b0) begin n_miss++; $display("FAIL aligned_clear: got %b exp 0", phv_out_valid); end
    endtask

    task automatic test_skew();
        logic [PHV_LEN-1:0] exp;
        exp = {pat6(7), pat4(7), pat2(7), 356'h2BAD};
        phv_out_ready = 1'b1;
        drive(1'b1, pat6(7), 1'b0, '0, 1'b0, '0, 1'b1, 356'h2BAD);
        tick();                                   // edge 1: remain + 6B
        idle();
        n_vec++;
        if (phv_out_valid !== 1'b0) begin n_miss++; $display("FAIL skew_e1: got %b exp 0", phv_out_valid); end
        drive(1'b0, '0, 1'b0, '0, 1'b1, pat2(7), 1'b0, '0);
        tick();                                   // edge 2: 2B
        idle();
        tick();                                   // edge 3
        n_vec++;
        if (phv_out_valid !== 1'b0) begin n_miss++; $display("FAIL skew_e3: got %b exp 0", phv_out_valid); end
        drive(1'b0, '0, 1'b1, pat4(7), 1'b0, '0, 1'b0, '0);
        tick();                                   // edge 4: 4B completes the set
        idle();
        n_vec++;
        if (phv_out_valid !== 1'b0) begin n_miss++; $display("FAIL skew_e4: got %b exp 0", phv_out_valid); end
        tick();                                   // edge 5
        n_vec++;
        if (phv_out_valid !== 1'b1) begin n_miss++; $display("FAIL skew_e5_valid: got %b exp 1", phv_out_valid); end
        n_vec++;
        if (phv_out !== exp) begin
            n_miss++;
            $display("FAIL skew_data: got[63:0]=%h exp[63:0]=%h diff_bits=%0d", phv_out[63:0], exp[63:0], $countones(phv_out ^ exp));
        end
        tick();
        n_vec++;
        if (phv_out_valid !== 1'b0) begin n_miss++; $display("FAIL skew_clear: got %b exp 0", phv_out_valid); end
    endtask

    task automatic test_backpressure();
        logic [PHV_LEN-1:0] exp_arr [3];
        for (int k = 1; k <= 3; k++) exp_arr[k-1] = {pat6(k), pat4(k), pat2(k), 356'(k)};
        phv_out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, pat6(k), 1'b1, pat4(k), 1'b1, pat2(k), 1'b1, 356'(k));
            tick();                               // edges 1..3
            if (k >= 2) begin
                n_vec++;
                if (phv_out_valid !== 1'b1 || phv_out !== exp_arr[0]) begin
                    n_miss++;
                    $display("FAIL bp_hold_e%0d: valid=%b got[63:0]=%h exp[63:0]=%h", k, phv_out_valid, phv_out[63:0], exp_arr[0][63:0]);
                end
            end
        end
        idle();
        for (int e = 4; e <= 5; e++) begin
            tick();
            n_vec++;
            if (phv_out_valid !== 1'b1 || phv_out !== exp_arr[0]) begin
                n_miss++;
                $display("FAIL bp_hold_e%0d: valid=%b got[63:0]=%h exp[63:0]=%h", e, phv_out_valid, phv_out[63:0], exp_arr[0][63:0]);
            end
        end
        phv_out_ready = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            tick();
            n_vec++;
            if (phv_out_valid !== 1'b1 || phv_out !== exp_arr[k]) begin
                n_miss++;
                $display("FAIL bp_drain_%0d: valid=%b got[63:0]=%h exp[63:0]=%h", k + 1, phv_out_valid, phv_out[63:0], exp_arr[k][63:0]);
            end
        end
        tick();
        n_vec++;
        if (phv_out_valid !== 1'b0) begin n_miss++; $display("FAIL bp_clear: got %b exp 0", phv_out_valid); end
    endtask

    task automatic test_overflow();
        logic [PHV_LEN-1:0] exp;
        logic exp_sr;
        logic [3:0] exp_ov;
        phv_out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 356'(k));
            tick();
            exp_sr = (k < 3);
            exp_ov = (k == 5) ? 4'b0001 : 4'b0000;
            n_vec++;
            if (stage_ready !== exp_sr) begin n_miss++; $display("FAIL ovf_stage_ready_p%0d: got %b exp %b", k, stage_ready, exp_sr); end
            n_vec++;
            if (overflow !== exp_ov) begin n_miss++; $display("FAIL ovf_flag_p%0d: got %b exp %b", k, overflow, exp_ov); end
        end
        idle();
        // Pair ALU sets with the four retained remain entries.
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, pat6(k), 1'b1, pat4(k), 1'b1, pat2(k), 1'b0, '0);
            tick();
            if (k > 1) begin
                exp = {pat6(k-1), pat4(k-1), pat2(k-1), 356'(k-1)};
                n_vec++;
                if (phv_out_valid !== 1'b1 || phv_out !== exp) begin
                    n_miss++;
                    $display("FAIL ovf_entry_%0d: valid=%b got[63:0]=%h exp[63:0]=%h", k - 1, phv_out_valid, phv_out[63:0], exp[63:0]);
                end
            end
        end
        idle();
        tick();
        exp = {pat6(4), pat4(4), pat2(4), 356'(4)};
        n_vec++;
        if (phv_out_valid !== 1'b1 || phv_out !== exp) begin
            n_miss++;
            $display("FAIL ovf_entry_4: valid=%b got[63:0]=%h exp[63:0]=%h", phv_out_valid, phv_out[63:0], exp[63:0]);
        end
        tick();
        n_vec++;
        if (phv_out_valid !== 1'b0) begin n_miss++; $display("FAIL ovf_drained: got %b exp 0", phv_out_valid); end
        n_vec++;
        if (overflow !== 4'b0001) begin n_miss++; $display("FAIL ovf_sticky: got %b exp 0001", overflow); end
        n_vec++;
        if (stage_ready !== 1'b1) begin n_miss++; $display("FAIL ovf_stage_ready_empty: got %b exp 1", stage_ready); end
        pulse_reset();
        tick();
        n_vec++;
        if (overflow !== 4'b0000) begin n_miss++; $display("FAIL ovf_cleared: got %b exp 0000", overflow); end
    endtask

    task automatic test_full_fire();
        logic [PHV_LEN-1:0] exp;
        phv_out_ready = 1'b0;
        // Set 1 lands in the output register, sets 2..5 fill every FIFO.
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, pat6(k + 10), 1'b1, pat4(k + 10), 1'b1, pat2(k + 10), 1'b1, 356'(k + 10));
            tick();
        end
        idle();
        n_vec++;
        if (stage_ready !== 1'b0) begin n_miss++; $display("FAIL full_stage_ready: got %b exp 0", stage_ready); end
        n_vec++;
        if (overflow !== 4'b0000) begin n_miss++; $display("FAIL full_no_ovf_pre: got %b exp 0000", overflow); end
        phv_out_ready = 1'b1;
        drive(1'b1, pat6(16), 1'b1, pat4(16), 1'b1, pat2(16), 1'b1, 356'(16));
        tick();
        idle();
        n_vec++;
        if (overflow !== 4'b0000) begin n_miss++; $display("FAIL full_push_pop_ovf: got %b exp 0000", overflow); end
        n_vec++;
        if (stage_ready !== 1'b0) begin n_miss++; $display("FAIL full_still_full: got %b exp 0", stage_ready); end
        // Everything from set 2 to set 6 must come out in order.
        for (int k = 2; k <= 6; k++) begin
            if (k > 2) tick();
            exp = {pat6(k + 10), pat4(k + 10), pat2(k + 10), 356'(k + 10)};
            n_vec++;
            if (phv_out_valid !== 1'b1 || phv_out !== exp) begin
                n_miss++;
                $display("FAIL full_drain_%0d: valid=%b got[63:0]=%h exp[63:0]=%h", k, phv_out_valid, phv_out[63:0], exp[63:0]);
            end
        end
        tick();
        n_vec++;
        if (phv_out_valid !== 1'b0) begin n_miss++; $display("FAIL full_clear: got %b exp 0", phv_out_valid); end
    endtask

    task automatic test_reset_mid();
        phv_out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, pat6(k), 1'b0, '0, 1'b0, '0, (k <= 2), 356'(k));
            tick();
        end
        idle();
        n_vec++;
        if (overflow !== 4'b1000 || stage_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL mid_pre: overflow=%b stage_ready=%b exp 1000/0", overflow, stage_ready);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (phv_out_valid !== 1'b0) begin n_miss++; $display("FAIL mid_rst_valid: got %b exp 0", phv_out_valid); end
        n_vec++;
        if (overflow !== 4'b0000) begin n_miss++; $display("FAIL mid_rst_overflow: got %b exp 0000", overflow); end
        n_vec++;
        if (stage_ready !== 1'b1) begin n_miss++; $display("FAIL mid_rst_stage_ready: got %b exp 1", stage_ready); end
        #2;
        rst_n = 1'b1;
        tick();
        // These would complete the discarded partial sets if they survived.
        for (int k = 1; k <= 2; k++) begin
            drive(1'b0, '0, 1'b1, pat4(k), 1'b1, pat2(k), 1'b0, '0);
            tick();
        end
        idle();
        for (int e = 0; e < 4; e++) begin
            tick();
            n_vec++;
            if (phv_out_valid !== 1'b0) begin n_miss++; $display("FAIL mid_no_output_%0d: got %b exp 0", e, phv_out_valid); end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_aligned();
        test_skew();
        test_backpressure();
        test_overflow();
        test_full_fire();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/phv_merger.md
PHV_MERGER -- requirements
Module: phv_merger

Interface
REQ-001 SHALL have parameter PHV_LEN, default 1124, total PHV width.
REQ-002 SHALL have parameter width_6B, default 48; width_4B, default 32; width_2B, default 16; container widths.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, entries per alignment FIFO (power of two, >=2).
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 alu_out_6B  input  384  eight 6B ALU results, container 7 in MSBs; alu_out_6B_valid  input  1.
REQ-007 alu_out_4B  input  256  eight 4B ALU results, container 7 in MSBs; alu_out_4B_valid  input  1.
REQ-008 alu_out_2B  input  128  eight 2B ALU results, container 7 in MSBs; alu_out_2B_valid  input  1.
REQ-009 phv_remain_data  input  356  metadata/conditional bits from crossbar; phv_remain_valid  input  1.
REQ-010 phv_out  output  PHV_LEN  reassembled PHV; phv_out_valid  output  1; phv_out_ready  input  1 (downstream accept).
REQ-011 stage_ready  output  1  upstream may issue a new PHV.
REQ-012 overflow  output  4  sticky drop flags {6B,4B,2B,remain}.

Function
REQ-013 SHALL hold four independent in-order FIFOs: 6B, 4B, 2B, remain; each pushes its data when its valid is high.
REQ-014 Groups SHALL be allowed to arrive on different cycles (unequal ALU latencies); the Nth entry of each FIFO belongs to the Nth PHV.
REQ-015 fire = all four FIFOs non-empty AND (phv_out_valid==0 OR phv_out_ready==1).
REQ-016 On fire, SHALL pop all four FIFOs in the same cycle and register phv_out = {6B, 4B, 2B, remain} (6B group in MSBs, remain in LSBs).
REQ-017 phv_out_valid SHALL rise on the edge where fire is sampled; SHALL clear on an edge where phv_out_ready==1 and fire==0.
REQ-018 While phv_out_valid==1 and phv_out_ready==0, phv_out SHALL stay stable and no FIFO SHALL pop.
REQ-019 Latency: all groups pushed at edge N into empty FIFOs with idle output -> phv_out_valid high after edge N+1; back-to-back PHVs sustain one per cycle with ready held high.
REQ-020 Push on a full FIFO in the same cycle as a pop SHALL be accepted (count unchanged).
REQ-021 Push on a full FIFO without a pop SHALL be dropped, FIFO contents unchanged, and the matching overflow bit SHALL set and stay set until reset.
REQ-022 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-023 stage_ready SHALL be 1 iff every FIFO count <= FIFO_DEPTH-2, registered (reflects counts after the previous edge).
REQ-024 No data bit SHALL be modified; block is pure alignment and concatenation.

Reset
REQ-025 On rst_n low, SHALL immediately empty all FIFOs (pointers and counts 0).
REQ-026 Reset values: phv_out 0, phv_out_valid 0, overflow 4'b0, stage_ready 1.
REQ-027 Reset asserted mid-operation SHALL discard all partially aligned PHVs; no output after release until fresh, complete input sets arrive.

Structure
REQ-028 PHV_LEN, container widths, container count (8) and remain width (356) SHALL live in shared package rmt_pkg.
REQ-029 One sub-module, merge_fifo (parameters WIDTH, DEPTH; push, pop, full, empty, count), SHALL be instantiated four times.
REQ-030 Fire logic, output register, overflow and stage_ready SHALL be in phv_merger top.

Verification
REQ-031 All four groups valid at edge 1 with 6B=all 0xAA, 4B=all 0x55, 2B=all 0x0F, remain=0x1 -> phv_out_valid after edge 2, phv_out = {384'hAA.., 256'h55.., 128'h0F.., 356'h1}.
REQ-032 remain and 6B at cycle 1, 2B at cycle 2, 4B at cycle 4 -> phv_out_valid only after edge 5, correct concatenation.
REQ-033 Three PHVs (remain=1,2,3) pushed back-to-back, phv_out_ready low for 5 cycles then high -> PHV 1 held stable, then 1,2,3 delivered on consecutive cycles in order.
REQ-034 Push 5 remain entries with no ALU data, DEPTH=4 -> overflow=4'b0001, stage_ready 0 after 3rd push, first 4 entries intact.
REQ-035 Full FIFOs, simultaneous push of 5th set and fire -> no overflow, count stays 4.
REQ-036 Assert rst_n low with 2 partial PHVs queued -> phv_out_valid 0, overflow 0, stage_ready 1 immediately; no output after release.
